// File: rtl/oled_spi_rx.sv
// Receive-side OLED panel model: samples the 4-wire SPI link and decodes command and data bytes into GRAM writes.
// Optional protocol error reporting (err_sticky/err_code) is enabled by defining OLED_SPI_RX_ERR_EN.
module oled_spi_rx #(
   parameter int COLS   = 128,
   parameter int PAGES  = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              oled_rst,
   input  logic              oled_cs,
   input  logic              oled_sclk,
   input  logic              oled_mosi,
   input  logic              oled_dc,
   output logic              gram_we,
   output logic [ADDR_W-1:0] gram_addr,
   output logic [7:0]        gram_wdata,
   output logic              cmd_valid,
   output logic [7:0]        cmd_byte,
   output logic              disp_on
`ifdef OLED_SPI_RX_ERR_EN
   ,
   output logic              err_sticky,
   output logic [1:0]        err_code
`endif
);
   localparam int CW = $clog2(COLS);
   localparam int PW = $clog2(PAGES);
   localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

   typedef enum logic [2:0] {S_IDLE, S_COL_S, S_COL_E, S_PAGE_S, S_PAGE_E} state_t;

   // Synchroniser bit order: {oled_rst, dc, cs, mosi, sclk}
   logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic       sclk_s, mosi_s, cs_s, dc_s, orst_s;
   logic       sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
   logic [7:0] shift_q, shift_d, rx_byte_q, rx_byte_d;
   logic [2:0] cnt_q, cnt_d;
   logic       rx_dc_q, rx_dc_d, byte_done_q, byte_done_d;
   logic       sclk_rise, cs_partial;

   assign {orst_s, dc_s, cs_s, mosi_s, sclk_s} = sync2_q;
   assign sclk_rise  = sclk_s & ~sclk_prev_q;
   assign cs_partial = cs_s & ~cs_prev_q & (cnt_q != 3'd0);

   always_comb begin
      sync1_d     = {oled_rst, oled_dc, oled_cs, oled_mosi, oled_sclk};
      sync2_d     = sync1_q;
      sclk_prev_d = sclk_s;
      cs_prev_d   = cs_s;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      rx_byte_d   = rx_byte_q;
      rx_dc_d     = rx_dc_q;
      byte_done_d = 1'b0;
      if (!orst_s) begin
         shift_d   = 8'd0;
         cnt_d     = 3'd0;
         rx_byte_d = 8'd0;
         rx_dc_d   = 1'b0;
      end else if (cs_s) begin
         shift_d = 8'd0;
         cnt_d   = 3'd0;
      end else if (sclk_rise) begin
         shift_d = {shift_q[6:0], mosi_s};
         cnt_d   = cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            rx_byte_d   = shift_d;
            rx_dc_d     = dc_s;
            byte_done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b0;
         shift_q     <= 8'd0;
         cnt_q       <= 3'd0;
         rx_byte_q   <= 8'd0;
         rx_dc_q     <= 1'b0;
         byte_done_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         sclk_prev_q <= sclk_prev_d;
         cs_prev_q   <= cs_prev_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         rx_byte_q   <= rx_byte_d;
         rx_dc_q     <= rx_dc_d;
         byte_done_q <= byte_done_d;
      end
   end

   state_t            state_q;
   logic [CW-1:0]     col_q, col_start_q, col_end_q;
   logic [PW-1:0]     page_q, page_start_q, page_end_q;
   logic              gram_we_q, cmd_valid_q, disp_on_q;
   logic [ADDR_W-1:0] gram_addr_q;
   logic [7:0]        gram_wdata_q, cmd_byte_q;
`ifdef OLED_SPI_RX_ERR_EN
   logic              err_sticky_q;
   logic [1:0]        err_code_q;
`endif

   // Byte handler; the synchronised panel reset clears it exactly like rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         col_q        <= '0;
         col_start_q  <= '0;
         col_end_q    <= CW'(COLS - 1);
         page_q       <= '0;
         page_start_q <= '0;
         page_end_q   <= PW'(PAGES - 1);
         gram_we_q    <= 1'b0;
         gram_addr_q  <= '0;
         gram_wdata_q <= 8'd0;
         cmd_valid_q  <= 1'b0;
         cmd_byte_q   <= 8'd0;
         disp_on_q    <= 1'b0;
`ifdef OLED_SPI_RX_ERR_EN
         err_sticky_q <= 1'b0;
         err_code_q   <= 2'b00;
`endif
      end else if (!orst_s) begin
         state_q      <= S_IDLE;
         col_q        <= '0;
         col_start_q  <= '0;
         col_end_q    <= CW'(COLS - 1);
         page_q       <= '0;
         page_start_q <= '0;
         page_end_q   <= PW'(PAGES - 1);
         gram_we_q    <= 1'b0;
         gram_addr_q  <= '0;
         gram_wdata_q <= 8'd0;
         cmd_valid_q  <= 1'b0;
         cmd_byte_q   <= 8'd0;
         disp_on_q    <= 1'b0;
`ifdef OLED_SPI_RX_ERR_EN
         err_sticky_q <= 1'b0;
         err_code_q   <= 2'b00;
`endif
      end else begin
         gram_we_q   <= 1'b0;
         cmd_valid_q <= 1'b0;
`ifdef OLED_SPI_RX_ERR_EN
         if (cs_partial && err_code_q == 2'b00) begin
            err_sticky_q <= 1'b1;
            err_code_q   <= 2'b01;
         end
`endif
         if (byte_done_q) begin
            if (rx_dc_q) begin
               // Data always wins: an unfinished address sequence is dropped.
`ifdef OLED_SPI_RX_ERR_EN
               if (state_q != S_IDLE && err_code_q == 2'b00) begin
                  err_sticky_q <= 1'b1;
                  err_code_q   <= 2'b10;
               end
`endif
               state_q      <= S_IDLE;
               gram_we_q    <= 1'b1;
               gram_addr_q  <= ADDR_W'(page_q) * COLS_A + ADDR_W'(col_q);
               gram_wdata_q <= rx_byte_q;
               if (col_q != col_end_q) begin
                  col_q <= col_q + 1'b1;
               end else begin
                  col_q <= col_start_q;
                  if (page_q == page_end_q) page_q <= page_start_q;
                  else                      page_q <= page_q + 1'b1;
               end
            end else begin
               case (state_q)
                  S_IDLE: begin
                     if (rx_byte_q == 8'h21) begin
                        state_q <= S_COL_S;
                     end else if (rx_byte_q == 8'h22) begin
                        state_q <= S_PAGE_S;
                     end else begin
                        cmd_valid_q <= 1'b1;
                        cmd_byte_q  <= rx_byte_q;
                        if (rx_byte_q == 8'hAF)      disp_on_q <= 1'b1;
                        else if (rx_byte_q == 8'hAE) disp_on_q <= 1'b0;
                     end
                  end
                  S_COL_S: begin
                     col_start_q <= CW'(rx_byte_q);
                     state_q     <= S_COL_E;
                  end
                  S_COL_E: begin
                     col_end_q <= CW'(rx_byte_q);
                     col_q     <= col_start_q;
                     state_q   <= S_IDLE;
                  end
                  S_PAGE_S: begin
                     page_start_q <= PW'(rx_byte_q);
                     state_q      <= S_PAGE_E;
                  end
                  S_PAGE_E: begin
                     page_end_q <= PW'(rx_byte_q);
                     page_q     <= page_start_q;
                     state_q    <= S_IDLE;
                  end
                  default: state_q <= S_IDLE;
               endcase
            end
         end
      end
   end

   assign gram_we    = gram_we_q;
   assign gram_addr  = gram_addr_q;
   assign gram_wdata = gram_wdata_q;
   assign cmd_valid  = cmd_valid_q;
   assign cmd_byte   = cmd_byte_q;
   assign disp_on    = disp_on_q;
`ifdef OLED_SPI_RX_ERR_EN
   assign err_sticky = err_sticky_q;
   assign err_code   = err_code_q;
`endif

endmodule

// File: tb/tb_oled_spi_rx.sv
// Directed plus randomized bench for oled_spi_rx, checked against a behavioural panel model.
// Error-port checks are included when OLED_SPI_RX_ERR_EN is defined.
module tb_oled_spi_rx;
   localparam int COLS   = 128;
   localparam int PAGES  = 8;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst_n, oled_rst, oled_cs, oled_sclk, oled_mosi, oled_dc;
   logic              gram_we, cmd_valid, disp_on;
   logic [ADDR_W-1:0] gram_addr;
   logic [7:0]        gram_wdata, cmd_byte;
`ifdef OLED_SPI_RX_ERR_EN
   logic              err_sticky;
   logic [1:0]        err_code;
`endif

   oled_spi_rx #(.COLS(COLS), .PAGES(PAGES), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .oled_rst(oled_rst), .oled_cs(oled_cs),
      .oled_sclk(oled_sclk), .oled_mosi(oled_mosi), .oled_dc(oled_dc),
      .gram_we(gram_we), .gram_addr(gram_addr), .gram_wdata(gram_wdata),
      .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .disp_on(disp_on)
`ifdef OLED_SPI_RX_ERR_EN
      , .err_sticky(err_sticky), .err_code(err_code)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int obs_wr[$], exp_wr[$], obs_cmd[$], exp_cmd[$];

   // Every strobe cycle is recorded, so a stretched pulse shows up as an extra entry.
   always @(negedge clk) begin
      if (gram_we)   obs_wr.push_back(int'({gram_addr, gram_wdata}));
      if (cmd_valid) obs_cmd.push_back(int'(cmd_byte));
   end

   // Panel model: window registers, cursor and pending-parameter position as plain integers.
   int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_pend, m_err, m_cmd;
   bit m_disp;

   task automatic m_reset();
      m_col = 0; m_page = 0; m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
      m_pend = 0; m_err = 0; m_cmd = 0; m_disp = 0;
   endtask

   task automatic model_byte(input bit dc, input int b);
      if (dc) begin
         if (m_pend != 0 && m_err == 0) m_err = 2;
         m_pend = 0;
         exp_wr.push_back((m_page * COLS + m_col) * 256 + b);
         if (m_col != m_ce) m_col = (m_col + 1) % COLS;
         else begin
            m_col = m_cs;
            m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % PAGES;
         end
      end else begin
         case (m_pend)
            0: if (b == 'h21) m_pend = 1;
               else if (b == 'h22) m_pend = 3;
               else begin
                  exp_cmd.push_back(b);
                  m_cmd = b;
                  if (b == 'hAF) m_disp = 1;
                  if (b == 'hAE) m_disp = 0;
               end
            1: begin m_cs = b % COLS;  m_pend = 2; end
            2: begin m_ce = b % COLS;  m_col  = m_cs; m_pend = 0; end
            3: begin m_ps = b % PAGES; m_pend = 4; end
            default: begin m_pe = b % PAGES; m_page = m_ps; m_pend = 0; end
         endcase
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare(input string tag);
      chk({tag, " wr_count"}, obs_wr.size(), exp_wr.size());
      chk({tag, " cmd_count"}, obs_cmd.size(), exp_cmd.size());
      while (obs_wr.size() > 0 && exp_wr.size() > 0)
         chk({tag, " wr addr/data"}, obs_wr.pop_front(), exp_wr.pop_front());
      while (obs_cmd.size() > 0 && exp_cmd.size() > 0)
         chk({tag, " cmd_byte"}, obs_cmd.pop_front(), exp_cmd.pop_front());
      obs_wr.delete(); exp_wr.delete(); obs_cmd.delete(); exp_cmd.delete();
      chk({tag, " disp_on"}, int'(disp_on), int'(m_disp));
      chk({tag, " held cmd_byte"}, int'(cmd_byte), m_cmd);
`ifdef OLED_SPI_RX_ERR_EN
      chk({tag, " err_code"}, int'(err_code), m_err);
      chk({tag, " err_sticky"}, int'(err_sticky), int'(m_err != 0));
`endif
   endtask

   task automatic shift_bits(input int n, input logic [7:0] b);
      for (int i = 7; i > 7 - n; i--) begin
         oled_mosi = b[i];
         oled_sclk = 1'b0; wait_clk(4);
         oled_sclk = 1'b1; wait_clk(4);
      end
   endtask

   task automatic send_byte(input bit dc, input logic [7:0] b);
      oled_dc = dc; oled_cs = 1'b0; wait_clk(3);
      shift_bits(8, b);
      oled_sclk = 1'b0; wait_clk(2);
      oled_cs = 1'b1; wait_clk(4);
      model_byte(dc, int'(b));
   endtask

   task automatic step(input bit dc, input logic [7:0] b, input string tag);
      send_byte(dc, b);
      compare(tag);
   endtask

   task automatic panel_reset();
      oled_rst = 1'b0; wait_clk(4);
      oled_rst = 1'b1; wait_clk(4);
      m_reset();
   endtask

   initial begin
      rst_n = 1'b0; oled_rst = 1'b1; oled_cs = 1'b1; oled_sclk = 1'b0;
      oled_mosi = 1'b0; oled_dc = 1'b0;
      m_reset();
      wait_clk(5);
      rst_n = 1'b1;
      wait_clk(5);

      chk("reset gram_we",    int'(gram_we), 0);
      chk("reset cmd_valid",  int'(cmd_valid), 0);
      chk("reset gram_addr",  int'(gram_addr), 0);
      chk("reset gram_wdata", int'(gram_wdata), 0);
      compare("reset");

      step(1'b0, 8'hAF, "display on");
      step(1'b0, 8'hAE, "display off");

      step(1'b1, 8'h11, "data0");
      step(1'b1, 8'h22, "data1");
      step(1'b1, 8'h33, "data2");

      panel_reset();
      step(1'b0, 8'h21, "col cmd");
      step(1'b0, 8'h04, "col start");
      step(1'b0, 8'h05, "col end");
      step(1'b0, 8'h22, "page cmd");
      step(1'b0, 8'h02, "page start");
      step(1'b0, 8'h03, "page end");
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), "window data");

      // Five edges then deselect: the fragment must vanish without a write.
      panel_reset();
      oled_cs = 1'b0; wait_clk(3);
      shift_bits(5, 8'hFF);
      oled_sclk = 1'b0; wait_clk(2);
      oled_cs = 1'b1; wait_clk(6);
      if (m_err == 0) m_err = 1;
      compare("partial byte");
      step(1'b1, 8'hA5, "after partial");

      panel_reset();
      step(1'b0, 8'h21, "abort col cmd");
      step(1'b0, 8'h10, "abort col start");
      step(1'b1, 8'h7E, "abort data");
      step(1'b0, 8'h55, "after abort cmd");

      step(1'b0, 8'h21, "rst col cmd");
      step(1'b0, 8'h04, "rst col start");
      step(1'b0, 8'h05, "rst col end");
      step(1'b0, 8'hAF, "rst display on");
      oled_dc = 1'b1; oled_cs = 1'b0; wait_clk(3);
      shift_bits(3, 8'hFF);
      oled_rst = 1'b0; wait_clk(4);
      oled_rst = 1'b1;
      oled_sclk = 1'b0; wait_clk(2);
      oled_cs = 1'b1; wait_clk(6);
      m_reset();
      compare("oled_rst mid byte");
      step(1'b1, 8'h5C, "after oled_rst");
      step(1'b1, 8'h5D, "after oled_rst next");

      // Random traffic: data, commands, full and abandoned window sequences, wide parameters.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: step(1'b1, 8'($urandom), "rand data");
            5: step(1'b0, 8'($urandom), "rand cmd");
            6: begin
               step(1'b0, 8'h21, "rand col cmd");
               step(1'b0, 8'($urandom), "rand col start");
               step(1'b0, 8'($urandom), "rand col end");
            end
            7: begin
               step(1'b0, 8'h22, "rand page cmd");
               step(1'b0, 8'($urandom), "rand page start");
               step(1'b0, 8'($urandom), "rand page end");
            end
            8: begin
               step(1'b0, ($urandom_range(0, 1) != 0) ? 8'h21 : 8'h22, "rand abort cmd");
               step(1'b0, 8'($urandom), "rand abort param");
               step(1'b1, 8'($urandom), "rand abort data");
            end
            default: step(1'b0, ($urandom_range(0, 1) != 0) ? 8'hAF : 8'hAE, "rand display");
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/oled_spi_rx.md
Name: oled_spi_rx

Overview:
- Receive-side model of the OLED panel controller: the far end of the 4-wire SPI link driven by oled_drive.
- Samples oled_sclk/oled_mosi/oled_cs/oled_dc in the system clock domain and assembles MSB-first bytes.
- Splits bytes into command and display-data traffic, decodes the addressing commands, and writes data bytes into a page-organised GRAM through a single write port.
- Used as a synthesizable panel stand-in for loopback tests and as the checker target in OLED benches.

Parameters:
- COLS, 128, columns per page; column index width is clog2(COLS).
- PAGES, 8, 8-pixel pages; page index width is clog2(PAGES).
- ADDR_W, 10, GRAM address width; must equal clog2(COLS*PAGES).

Ports:
- clk  input  1  system clock; must run at least 4x oled_sclk.
- rst_n  input  1  asynchronous active-low reset.
- oled_rst  input  1  panel reset from master, active-low; synchronised, acts as a synchronous clear of all decoder state.
- oled_cs  input  1  chip select, active-low.
- oled_sclk  input  1  SPI clock; data is sampled on its rising edge.
- oled_mosi  input  1  serial data, MSB first.
- oled_dc  input  1  0 = command byte, 1 = data byte.
- gram_we  output  1  one-cycle GRAM write strobe.
- gram_addr  output  ADDR_W  write address, page*COLS + col.
- gram_wdata  output  8  write data.
- cmd_valid  output  1  one-cycle strobe for a completed command byte not consumed as an address parameter.
- cmd_byte  output  8  that command byte; held until the next cmd_valid.
- disp_on  output  1  display state: 0xAF sets it, 0xAE clears it.

Behaviour:
- Reset (rst_n low, or synchronised oled_rst low) sets every output and internal register to 0, with these exceptions:
  - col_end = COLS-1.
  - page_end = PAGES-1.
  - col_start, page_start, col and page = 0.
- Synchronisers: sclk, mosi, cs, dc and oled_rst each pass through a 2-FF synchroniser.
- A rising edge is declared when the synchronised sclk is 1 now and was 0 on the previous cycle.
- Bit capture:
  - On a detected edge while synchronised cs is 0, shift mosi into an 8-bit shift register and increment a 3-bit bit counter.
  - On the 8th bit, latch the byte and the synchronised dc value, then raise an internal byte_done for one cycle.
- cs high clears the bit counter and discards any partial byte. Edges seen while cs is high are ignored.
- Byte handler state machine, evaluated on byte_done:
  - IDLE
    - dc=1: GRAM write at the current {page, col}, then advance the address.
    - dc=0, byte 0x21: go to COL_S.
    - dc=0, byte 0x22: go to PAGE_S.
    - dc=0, byte 0xAE or 0xAF: update disp_on and pulse cmd_valid.
    - dc=0, any other byte: pulse cmd_valid only.
  - COL_S: the byte becomes col_start; go to COL_E.
  - COL_E: the byte becomes col_end; col = col_start; go to IDLE.
  - PAGE_S: the byte becomes page_start; go to PAGE_E.
  - PAGE_E: the byte becomes page_end; page = page_start; go to IDLE.
- Parameter bytes are truncated to the index width; for example a column value of 0xFF with COLS=128 gives 127.
- A dc=1 byte that arrives while in COL_S/COL_E/PAGE_S/PAGE_E abandons the sequence. Already-latched parameters are kept, the state returns to IDLE, and the byte is handled as a normal data write.
- Address advance (horizontal addressing):
  - If col != col_end: col+1.
  - Else: col = col_start, and page advances. If page == page_end, page = page_start; otherwise page+1.
- If start > end, the counter runs forward until it wraps modulo its width and then reaches end. No error is flagged for this case.
- Latency: gram_we and cmd_valid assert exactly 1 clk after byte_done. gram_addr and gram_wdata are valid in the same cycle as gram_we.
- Minimum spacing between two byte_done pulses is 8 sclk periods, so the outputs can never overlap.

Optional Feature:
- Macro: OLED_SPI_RX_ERR_EN.
- When defined, adds two outputs:
  - err_sticky (1 bit): set on either of two protocol errors:
    - a cs rising edge while the bit counter is nonzero;
    - a dc=1 byte arriving in a parameter state.
  - err_code (2 bits): 01 = partial byte, 10 = aborted parameter. It captures the first error only.
- err_sticky and err_code are cleared only by reset or oled_rst.
- When undefined, neither port exists and errors are silently tolerated as described in Behaviour.

Test Plan:
- Reset, then send dc=0 0xAF -> cmd_valid pulses with cmd_byte=0xAF, disp_on=1. Then send 0xAE -> disp_on=0.
- Send dc=1 bytes 0x11, 0x22, 0x33 after reset -> three gram_we pulses at addr 0, 1, 2 with data 0x11, 0x22, 0x33.
- Send 0x21,0x04,0x05 then 0x22,0x02,0x03, followed by 5 data bytes -> addresses 260, 261, 388, 389, 260.
- Send cs low, 5 sclk edges, cs high, then a full data byte 0xA5 -> exactly one gram_we, data 0xA5, addr 0. With OLED_SPI_RX_ERR_EN defined: err_code=01.
- Send 0x21,0x10 then dc=1 byte 0x7E -> write at addr 0 (col_start=16 latched, col not reloaded); no cmd_valid. With the macro: err_code=10.
- Pull oled_rst low for 4 clk in the middle of a byte -> the partial byte is dropped, the window returns to 0..127/0..7, and the next data byte lands at addr 0.
